// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// decode_stage: one-cycle RV32I/RV32E decode with register-file read, writeback
// bypass and a busy-register scoreboard that holds fetch on RAW/WAW hazards.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int USE_SB = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic [4:0]      rs1_num,
  output logic [4:0]      rs2_num,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] op3,
  output logic [4:0]      rd,
  output logic [31:0]     out_instr,
  output logic            illegal
);

  localparam logic [6:0]  OPC_R      = 7'b0110011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [31:0] NO_OP      = 32'h0000_0013;
  localparam logic [5:0]  NREG_L     = 6'(NREG);

  logic [6:0]      opcode;
  logic [4:0]      rd_field;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic            byp1, byp2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            known, use_rs1, use_rs2, use_rd;
  logic [XLEN-1:0] d_op1, d_op2, d_op3;
  logic            bad_reg, is_illegal;
  logic [4:0]      rd_eff;
  logic [31:0]     busy_ext;
  logic            hazard, accept;

  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     instr_q, instr_d;
  logic            illegal_q, illegal_d;

  assign opcode   = instr[6:0];
  assign rd_field = instr[11:7];
  assign rs1_num  = instr[19:15];
  assign rs2_num  = instr[24:20];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

  // A same-cycle writeback overrides the register file; x0 is hard-wired zero.
  assign byp1    = wb_valid && (wb_rd == rs1_num) && (rs1_num != 5'd0);
  assign byp2    = wb_valid && (wb_rd == rs2_num) && (rs2_num != 5'd0);
  assign rs1_val = (rs1_num == 5'd0) ? '0 : (byp1 ? wb_data : rs1_data);
  assign rs2_val = (rs2_num == 5'd0) ? '0 : (byp2 ? wb_data : rs2_data);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    known   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    d_op1   = '0;
    d_op2   = '0;
    d_op3   = '0;
    case (opcode)
      OPC_R: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        d_op1   = rs1_val;
        d_op2   = rs2_val;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        use_rs1 = 1'b1; use_rd = 1'b1;
        d_op1   = rs1_val;
        d_op2   = imm_i;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_op1   = rs1_val;
        d_op2   = imm_s;
        d_op3   = rs2_val;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_op1   = rs1_val;
        d_op2   = rs2_val;
        d_op3   = imm_b;
      end
      OPC_JAL: begin
        use_rd = 1'b1;
        d_op1  = imm_j;
      end
      OPC_LUI, OPC_AUIPC: begin
        use_rd = 1'b1;
        d_op1  = imm_u;
      end
      default: known = 1'b0;
    endcase
  end

  assign bad_reg = (use_rs1 && ({1'b0, rs1_num}  >= NREG_L)) ||
                   (use_rs2 && ({1'b0, rs2_num}  >= NREG_L)) ||
                   (use_rd  && ({1'b0, rd_field} >= NREG_L));
  assign is_illegal = !known || bad_reg;
  assign rd_eff     = (use_rd && !is_illegal) ? rd_field : 5'd0;

  always_comb begin
    busy_ext             = '0;
    busy_ext[NREG-1:0]   = busy_q;
  end

  // Illegal instructions pass straight through: they neither stall nor reserve rd.
  always_comb begin
    hazard = 1'b0;
    if (USE_SB != 0 && in_valid && !is_illegal) begin
      if (use_rs1 && rs1_num != 5'd0 && busy_ext[rs1_num] && !byp1) hazard = 1'b1;
      if (use_rs2 && rs2_num != 5'd0 && busy_ext[rs2_num] && !byp2) hazard = 1'b1;
      if (rd_eff != 5'd0 && busy_ext[rd_eff] && !(wb_valid && wb_rd == rd_eff)) hazard = 1'b1;
    end
  end

  assign in_ready = !rst && (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Set is applied after clear so a same-edge set/clear on one register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (wb_valid && wb_rd == 5'(i)) busy_d[i] = 1'b0;
      if (accept && rd_eff != 5'd0 && rd_eff == 5'(i)) busy_d[i] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    op3_d       = op3_q;
    rd_d        = rd_q;
    instr_d     = instr_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op1_d       = is_illegal ? '0 : d_op1;
      op2_d       = is_illegal ? '0 : d_op2;
      op3_d       = is_illegal ? '0 : d_op3;
      rd_d        = rd_eff;
      instr_d     = instr;
      illegal_d   = is_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      op3_q       <= '0;
      rd_q        <= 5'd0;
      instr_q     <= NO_OP;
      illegal_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      op3_q       <= op3_d;
      rd_q        <= rd_d;
      instr_q     <= instr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign op3       = op3_q;
  assign rd        = rd_q;
  assign out_instr = instr_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised RV32I/RV32E instruction decode stage with valid/ready handshakes, register-file read, writeback bypass and a busy-register scoreboard. It sits between fetch and execute. It produces the same op1/op2/op3/rd operand convention as the existing single-shot decoder, and it stalls fetch on RAW and WAW hazards.

## Interface
- XLEN, 32 — datapath width. Immediates are sign-extended to XLEN.
- NREG, 32 — architectural registers, 32 or 16 (RV32E).
- USE_SB, 1 — 1 enables scoreboard stalls; 0 means in_ready ignores hazards.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents instr.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  32  instruction word.
- rs1_num, rs2_num  out  5  register-file read indices, driven combinationally from instr fields.
- rs1_data, rs2_data  in  XLEN  register-file read data, combinational, same cycle.
- wb_valid  in  1  writeback this cycle.
- wb_rd  in  5  writeback register.
- wb_data  in  XLEN  writeback value.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- op1, op2, op3  out  XLEN  operands.
- rd  out  5  destination register, 0 if there is none.
- out_instr  out  32  registered copy of instr.
- illegal  out  1  opcode unrecognised or register index ≥ NREG.

## Operation

**Operand mapping.** Classes are by opcode[6:0].
- R (0110011): op1=rs1, op2=rs2, rd=rd.
- I-ALU (0010011, including SLTI/SLTIU and shifts), loads (0000011), JALR (1100111): op1=rs1, op2=imm_I, rd=rd.
- S (0100011): op1=rs1, op2=imm_S, op3=rs2, rd=0.
- B (1100011): op1=rs1, op2=rs2, op3=imm_B, rd=0.
- JAL (1101111): op1=imm_J, rd=rd.
- LUI (0110111), AUIPC (0010111): op1=instr[31:12]<<12, rd=rd.
- Every unused operand is 0.

**Immediates.**
- imm_I = sext(instr[31:20]); shifts use the same rule.
- imm_S = sext({instr[31:25], instr[11:7]}).
- imm_B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- imm_J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).

**Register read.**
- Index 0 reads 0 regardless of rs*_data.
- If wb_valid && wb_rd==rsN && rsN!=0, wb_data is used (bypass).

**Illegal.**
- Applies to an unknown opcode, or any used register field ≥ NREG.
- Output is illegal=1 with op1..op3=0 and rd=0.
- The instruction is not stalled and does not set the scoreboard.

**Scoreboard.** busy[NREG-1:0].
- A bit is set on acceptance of an instruction with rd!=0.
- A bit is cleared on wb_valid for wb_rd.
- If set and clear hit the same register on the same edge, set wins.

**Hazard stall** (USE_SB=1). in_valid with any of:
- a used rsN is busy and not bypassed this cycle;
- a nonzero rd is busy and not being cleared this cycle.

**Handshake.**
- in_ready = (!out_valid || out_ready) && !hazard.
- Transfer in occurs when in_valid && in_ready.
- Transfer out occurs when out_valid && out_ready.
- Output registers hold while out_valid && !out_ready.

## Timing
- Reset (asynchronous): out_valid=0, op1/op2/op3=0, rd=0, out_instr=NO_OP (0x00000013), illegal=0, busy=0.
- Latency is 1: an instruction accepted at edge N appears with out_valid=1 after edge N.
- Full throughput: one instruction per cycle with no hazards and out_ready=1.
- out_valid falls after an edge with an out transfer and no in transfer.
- Operands are captured at acceptance. A later writeback does not alter a held bundle.
- Reset asserted mid-stall clears the pipeline and the scoreboard immediately. in_ready is 0 while rst=1.
- rs*_num follow instr combinationally. in_ready depends combinationally on out_ready, wb_* and instr.

## Test plan
- **Reset/idle.** Assert rst for 5 cycles → out_valid=0, in_ready=0 during reset, busy=0. After release, in_ready=1.
- **Per-class mapping.** Set RF[i]=i. Issue each opcode class with rd=5, rs1=1, rs2=2, imm field 0x12345678 (e.g. ADD → op1=1, op2=2, rd=5; SW → op1=1, op2=imm_S, op3=2, rd=0; LUI → op1=0x12345000). Each bundle must appear exactly 1 cycle after acceptance.
- **RAW stall and bypass.**
  - ADDI x3 accepted, then ADD x4,x3,x3 presented → in_ready=0 until wb_valid, wb_rd=3, wb_data=0xDEAD.
  - In that same cycle the ADD is accepted with op1=op2=0xDEAD.
- **WAW and set-wins.**
  - ADDI x7 pending, second ADDI x7 presented → stalls.
  - On the wb for x7 the second ADDI is accepted and busy[7] remains 1.
- **Backpressure.** Hold out_ready=0 for 4 cycles with in_valid=1 → the bundle is held stable, in_ready=0, and no instruction is lost or duplicated.
- **Edge cases.**
  - rd=x0 → no scoreboard set.
  - rs=x0 → reads 0.
  - NREG=16 with rs1=20 → illegal=1 and zero operands.
  - 1000 random legal instructions compared against an independent oracle.
